// File: rtl/pipe_lzc_normalize.sv
// Pipelined normalization stage placed after the pipelined leading-zero counter.
// Delay-matches mantissa/exponent to the counter latency, then left-shifts the
// mantissa by the leading-zero count (limited by the exponent) and adjusts the
// exponent. One operand per cycle, no backpressure. Latency is LZC_LAT + 3.
//
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   in_valid           in_mant / in_exp valid this cycle
//   in_mant, in_exp    unnormalized mantissa and biased exponent (0 = subnormal)
//   lzc                leading-zero count of in_mant, LZC_LAT cycles later
//   out_valid          result valid this cycle
//   out_mant, out_exp  normalized mantissa and adjusted exponent
//   out_zero, out_sub  result is zero / result is subnormal
module pipe_lzc_normalize #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned EXP_W   = 11,
    parameter int unsigned LZC_LAT = 1,
    parameter int unsigned CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [CNT_W-1:0] lzc,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_sub
);

    localparam int unsigned XW = EXP_W + 1;

    // Stage D: delay line aligning operands with the incoming lzc
    logic [LZC_LAT-1:0] d_valid_q;
    logic [WIDTH-1:0]   d_mant_q [LZC_LAT];
    logic [EXP_W-1:0]   d_exp_q  [LZC_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid_q <= '0;
            for (int i = 0; i < LZC_LAT; i++) begin
                d_mant_q[i] <= '0;
                d_exp_q[i]  <= '0;
            end
        end else begin
            d_valid_q[0] <= in_valid;
            d_mant_q[0]  <= in_mant;
            d_exp_q[0]   <= in_exp;
            for (int i = 1; i < LZC_LAT; i++) begin
                d_valid_q[i] <= d_valid_q[i-1];
                d_mant_q[i]  <= d_mant_q[i-1];
                d_exp_q[i]   <= d_exp_q[i-1];
            end
        end
    end

    logic             t_valid;
    logic [WIDTH-1:0] t_mant;
    logic [EXP_W-1:0] t_exp;

    assign t_valid = d_valid_q[LZC_LAT-1];
    assign t_mant  = d_mant_q[LZC_LAT-1];
    assign t_exp   = d_exp_q[LZC_LAT-1];

    // Stage 1: shift/exponent decision, widened by one bit so nothing wraps
    logic [XW-1:0]    t_exp_x;
    logic [XW-1:0]    t_lzc_x;
    logic [CNT_W-1:0] s1_sh_d;
    logic [EXP_W-1:0] s1_exp_d;
    logic             s1_zero_d;
    logic             s1_sub_d;

    assign t_exp_x = {1'b0, t_exp};
    assign t_lzc_x = XW'(lzc);

    always_comb begin
        s1_sh_d   = '0;
        s1_exp_d  = '0;
        s1_zero_d = 1'b0;
        s1_sub_d  = 1'b0;
        // >= also absorbs out-of-range counts, keeping sh <= WIDTH-1
        if (lzc >= CNT_W'(WIDTH)) begin
            s1_zero_d = 1'b1;
        end else if (t_exp == '0) begin
            s1_sub_d = 1'b1;
        end else if (t_lzc_x < t_exp_x) begin
            s1_sh_d  = lzc;
            s1_exp_d = EXP_W'(t_exp_x - t_lzc_x);
        end else begin
            // Exponent runs out first: shift only down to the subnormal scale
            s1_sh_d  = CNT_W'(t_exp_x - XW'(1));
            s1_sub_d = 1'b1;
        end
    end

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_mant_q;
    logic [CNT_W-1:0] s1_sh_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic             s1_zero_q;
    logic             s1_sub_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_sh_q    <= '0;
            s1_exp_q   <= '0;
            s1_zero_q  <= 1'b0;
            s1_sub_q   <= 1'b0;
        end else begin
            s1_valid_q <= t_valid;
            if (t_valid) begin
                s1_mant_q <= t_mant;
                s1_sh_q   <= s1_sh_d;
                s1_exp_q  <= s1_exp_d;
                s1_zero_q <= s1_zero_d;
                s1_sub_q  <= s1_sub_d;
            end
        end
    end

    // Stage 2: coarse shift by whole bytes
    logic [CNT_W-1:0] coarse_amt;
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_mant_q;
    logic [2:0]       s2_fine_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic             s2_zero_q;
    logic             s2_sub_q;

    assign coarse_amt = {s1_sh_q[CNT_W-1:3], 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_mant_q  <= '0;
            s2_fine_q  <= '0;
            s2_exp_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_sub_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_mant_q <= s1_mant_q << coarse_amt;
                s2_fine_q <= s1_sh_q[2:0];
                s2_exp_q  <= s1_exp_q;
                s2_zero_q <= s1_zero_q;
                s2_sub_q  <= s1_sub_q;
            end
        end
    end

    // Stage 3: fine shift into the output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_sub   <= 1'b0;
        end else begin
            out_valid <= s2_valid_q;
            if (s2_valid_q) begin
                out_mant <= s2_zero_q ? '0 : (s2_mant_q << s2_fine_q);
                out_exp  <= s2_exp_q;
                out_zero <= s2_zero_q;
                out_sub  <= s2_sub_q;
            end
        end
    end

endmodule

// File: tb/tb_pipe_lzc_normalize.sv
// Self-checking bench for pipe_lzc_normalize (WIDTH=64, EXP_W=11, LZC_LAT=1).
// A registered leading-zero counter stands in for pipe_lzc upstream.
module tb_pipe_lzc_normalize;

    localparam int W   = 64;
    localparam int EW  = 11;
    localparam int LAT = 1;
    localparam int CW  = 7;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_mant  = '0;
    logic [EW-1:0] in_exp   = '0;
    logic [CW-1:0] lzc;
    logic          out_valid;
    logic [W-1:0]  out_mant;
    logic [EW-1:0] out_exp;
    logic          out_zero;
    logic          out_sub;

    pipe_lzc_normalize #(
        .WIDTH  (W),
        .EXP_W  (EW),
        .LZC_LAT(LAT),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_mant  (in_mant),
        .in_exp   (in_exp),
        .lzc      (lzc),
        .out_valid(out_valid),
        .out_mant (out_mant),
        .out_exp  (out_exp),
        .out_zero (out_zero),
        .out_sub  (out_sub)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  mant;
        logic [EW-1:0] exp;
        logic          zero;
        logic          sub;
        int            cyc;
    } res_t;

    res_t sb[$];
    res_t last;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    function automatic int lz_count(input logic [W-1:0] m);
        int n;
        n = W;
        for (int i = 0; i < W; i++) if (m[i]) n = W - 1 - i;
        return n;
    endfunction

    // Upstream counter: one register stage, not qualified by valid
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lzc <= '0;
        else        lzc <= CW'(lz_count(in_mant));
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [W-1:0] m, input logic [EW-1:0] e);
        res_t r;
        int   lz;
        int   sh;
        lz     = lz_count(m);
        sh     = 0;
        r.zero = 1'b0;
        r.sub  = 1'b0;
        r.exp  = '0;
        if (lz == W) r.zero = 1'b1;
        else if (e == 0) r.sub = 1'b1;
        else if (lz < int'(e)) begin
            sh    = lz;
            r.exp = e - EW'(lz);
        end else begin
            sh    = int'(e) - 1;
            r.sub = 1'b1;
        end
        r.mant = r.zero ? '0 : (m << sh);
        r.cyc  = 0;
        return r;
    endfunction

    function automatic res_t mk(input logic [W-1:0] m, input logic [EW-1:0] e,
                                input logic z, input logic s);
        res_t r;
        r.mant = m;
        r.exp  = e;
        r.zero = z;
        r.sub  = s;
        r.cyc  = 0;
        return r;
    endfunction

    function automatic logic [W-1:0] mant_with_lz(input int lz);
        logic [W-1:0] top;
        logic [W-1:0] rnd;
        if (lz >= W) return '0;
        top = {1'b1, {(W-1){1'b0}}} >> lz;
        rnd = {$urandom, $urandom};
        return top | (rnd & (top - 1));
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        last     = mk('0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, out_mant, out_exp, out_zero, out_sub} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b mant=%h exp=%0d z=%b s=%b want all 0",
                     out_valid, out_mant, out_exp, out_zero, out_sub);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || out_mant !== '0) begin
                n_bad++;
                $display("FAIL reset_release: got v=%b mant=%h want v=0 mant=0",
                         out_valid, out_mant);
            end
        end
    endtask

    // Back-to-back directed vectors, including the boundary cases
    task automatic test_directed();
        logic [W-1:0]  dm [8];
        logic [EW-1:0] de [8];
        res_t          dx [8];
        res_t          e;
        dm = '{64'h0000_0001_0000_0000, 64'h00F0_0000_0000_0000, 64'h0,
               64'h8000_0000_0000_0000, 64'h0000_0000_0000_00FF, 64'h1,
               64'h1, 64'h00F0_0000_0000_0000};
        de = '{11'd100, 11'd5, 11'd300, 11'd1, 11'd0, 11'd1, 11'd64, 11'd2047};
        dx[0] = mk(64'h8000_0000_0000_0000, 11'd69, 1'b0, 1'b0);
        dx[1] = mk(64'h0F00_0000_0000_0000, 11'd0, 1'b0, 1'b1);
        dx[2] = mk(64'h0, 11'd0, 1'b1, 1'b0);
        dx[3] = mk(64'h8000_0000_0000_0000, 11'd1, 1'b0, 1'b0);
        dx[4] = mk(64'h0000_0000_0000_00FF, 11'd0, 1'b0, 1'b1);
        dx[5] = mk(64'h1, 11'd0, 1'b0, 1'b1);
        dx[6] = mk(64'h8000_0000_0000_0000, 11'd1, 1'b0, 1'b0);
        dx[7] = mk(64'hF000_0000_0000_0000, 11'd2039, 1'b0, 1'b0);
        for (int i = 0; i < 8 + 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL dir_spurious: got out_valid=1 want 0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (cyc != e.cyc + LAT + 3) begin
                        n_bad++;
                        $display("FAIL dir_latency: got %0d want %0d", cyc - e.cyc, LAT + 3);
                    end
                    n_cmp++;
                    if ({out_mant, out_exp, out_zero, out_sub} !== {e.mant, e.exp, e.zero, e.sub})
                    begin
                        n_bad++;
                        $display("FAIL dir_result: got mant=%h exp=%0d z=%b s=%b want mant=%h exp=%0d z=%b s=%b",
                                 out_mant, out_exp, out_zero, out_sub,
                                 e.mant, e.exp, e.zero, e.sub);
                    end
                    last = e;
                end
            end else begin
                n_cmp++;
                if ({out_mant, out_exp, out_zero, out_sub} !==
                    {last.mant, last.exp, last.zero, last.sub}) begin
                    n_bad++;
                    $display("FAIL dir_hold: got mant=%h exp=%0d want mant=%h exp=%0d",
                             out_mant, out_exp, last.mant, last.exp);
                end
            end
            if (i < 8) begin
                in_valid = 1'b1;
                in_mant  = dm[i];
                in_exp   = de[i];
                e        = dx[i];
                e.cyc    = cyc;
                sb.push_back(e);
            end else begin
                in_valid = 1'b0;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL dir_drain: got %0d results outstanding want 0", sb.size());
        end
        sb.delete();
    endtask

    // Random stream with bubbles; first 64 operands sweep sh = 0..63
    task automatic test_stream();
        res_t e;
        int   n_ops;
        int   drain;
        int   lz;
        n_ops = 0;
        drain = 0;
        while (n_ops < 200 || drain < 10) begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL stream_spurious: got out_valid=1 want 0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (cyc != e.cyc + LAT + 3) begin
                        n_bad++;
                        $display("FAIL stream_latency: got %0d want %0d", cyc - e.cyc, LAT + 3);
                    end
                    n_cmp++;
                    if ({out_mant, out_exp, out_zero, out_sub} !== {e.mant, e.exp, e.zero, e.sub})
                    begin
                        n_bad++;
                        $display("FAIL stream_result: got mant=%h exp=%0d z=%b s=%b want mant=%h exp=%0d z=%b s=%b",
                                 out_mant, out_exp, out_zero, out_sub,
                                 e.mant, e.exp, e.zero, e.sub);
                    end
                    if (!out_zero && !out_sub) begin
                        n_cmp++;
                        if (out_mant[W-1] !== 1'b1) begin
                            n_bad++;
                            $display("FAIL stream_msb: got msb=%b want 1", out_mant[W-1]);
                        end
                    end
                    last = e;
                end
            end else begin
                n_cmp++;
                if ({out_mant, out_exp, out_zero, out_sub} !==
                    {last.mant, last.exp, last.zero, last.sub}) begin
                    n_bad++;
                    $display("FAIL stream_hold: got mant=%h exp=%0d want mant=%h exp=%0d",
                             out_mant, out_exp, last.mant, last.exp);
                end
            end
            if (n_ops < 200 && $urandom_range(0, 3) != 0) begin
                if (n_ops < 64) begin
                    in_mant = mant_with_lz(n_ops);
                    in_exp  = EW'($urandom_range(n_ops + 1, 2047));
                end else begin
                    lz      = ($urandom_range(0, 9) == 0) ? W : int'($urandom_range(0, W - 1));
                    in_mant = mant_with_lz(lz);
                    case ($urandom_range(0, 3))
                        0:       in_exp = '0;
                        1:       in_exp = EW'($urandom_range(1, 70));
                        default: in_exp = EW'($urandom_range(1, 2047));
                    endcase
                end
                in_valid = 1'b1;
                e        = model(in_mant, in_exp);
                e.cyc    = cyc;
                sb.push_back(e);
                n_ops++;
            end else begin
                in_valid = 1'b0;
                in_mant  = {$urandom, $urandom};
                in_exp   = EW'($urandom);
                if (n_ops >= 200) drain++;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL stream_drain: got %0d results outstanding want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_mant  = mant_with_lz(3 + i);
            in_exp   = 11'd500;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_pre: got out_valid=%b want 1", out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_mant, out_exp, out_zero, out_sub} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_async: got v=%b mant=%h exp=%0d z=%b s=%b want all 0",
                     out_valid, out_mant, out_exp, out_zero, out_sub);
        end
        sb.delete();
        last = mk('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_mant, out_exp, out_zero, out_sub} !== '0) begin
                n_bad++;
                $display("FAIL rst_mid_after: got v=%b mant=%h exp=%0d want all 0",
                         out_valid, out_mant, out_exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_lzc_normalize.md
Name: pipe_lzc_normalize

Overview:
Pipelined normalization stage that sits directly downstream of the pipelined leading-zero counter, pipe_lzc, in the floating-point datapath. It delay-matches the mantissa and exponent to the counter's latency. It then left-shifts the mantissa by the leading-zero count, limited by the exponent, and adjusts the exponent. Outputs are flagged as zero or subnormal. The block streams one operand per cycle and has no backpressure.

Parameters:
WIDTH, 64, mantissa width in bits; must be >= 8.
EXP_W, 11, exponent width in bits; must be >= CNT_W.
LZC_LAT, 1, cycles from in_mant being presented to the matching lzc value at this block's input; must be >= 1.
CNT_W, $clog2(WIDTH+1), width of the leading-zero count.

Ports:
clk  in  1  clock; all registers are clocked on the rising edge.
rst_n  in  1  reset; asynchronous, active-low.
in_valid  in  1  in_mant and in_exp are valid this cycle.
in_mant  in  WIDTH  unnormalized mantissa; also drives pipe_lzc.din.
in_exp  in  EXP_W  biased exponent; 0 denotes the subnormal scale, equivalent to 1.
lzc  in  CNT_W  leading-zero count of in_mant, arriving LZC_LAT cycles after in_mant; not qualified by any valid signal.
out_valid  out  1  outputs are valid this cycle.
out_mant  out  WIDTH  normalized mantissa.
out_exp  out  EXP_W  adjusted exponent.
out_zero  out  1  result is zero.
out_sub  out  1  result is subnormal (out_exp = 0 and MSB not forced).

Behaviour:
- Reset (rst_n = 0):
  - All valid bits clear immediately (asynchronous).
  - All data registers and outputs reset to 0.
  - In-flight operands are discarded; no stale out_valid appears after rst_n rises.
- Stage D (delay line):
  - LZC_LAT-deep shift register carries in_valid, in_mant and in_exp.
  - Its tail aligns with the lzc input.
  - Valid bits shift every cycle; data registers load every cycle.
- Stage 1 (decision, registered); with m, e the delayed mantissa and exponent:
  - lzc == WIDTH: zero = 1, sh = 0, e' = 0, sub = 0.
  - else e == 0: sh = 0, e' = 0, sub = 1.
  - else lzc < e: sh = lzc, e' = e - lzc, sub = 0.
  - else: sh = e - 1, e' = 0, sub = 1.
  - sh is always <= WIDTH-1.
  - Exponent subtraction is computed at EXP_W+1 bits so it cannot wrap.
- Stage 2 (coarse shift, registered): m << (8 * sh[CNT_W-1:3]); zero-fill from the LSB.
- Stage 3 (fine shift, registered): result << sh[2:0].
  - When zero = 1, out_mant is forced to 0.
  - Drives the output registers.
- Latency:
  - out_valid asserts exactly LZC_LAT + 3 cycles after in_valid.
  - Throughput is one operand per cycle.
  - Bubbles propagate unchanged.
- Hold behaviour:
  - Stage 1 to 3 data registers and all outputs are clock-enabled by their stage valid.
  - While out_valid = 0, out_mant, out_exp, out_zero and out_sub hold the last valid result (0 after reset).
- Simultaneous events:
  - A new operand may enter on the same cycle another leaves; there is no interaction between them.
  - lzc is sampled only when the tail of the delay line is valid.
- Flag exclusivity: out_zero and out_sub are never both 1.
- Invariant: out_mant[WIDTH-1] = 1 whenever out_valid = 1, out_zero = 0 and out_sub = 0.

Test Plan:
(All scenarios use WIDTH=64, EXP_W=11, LZC_LAT=1, with pipe_lzc instantiated upstream. pipe_lzc registers its output once, so lzc arrives one cycle after din.)
1. Basic normalize: in_mant=0x0000_0001_0000_0000, in_exp=100 (lz=31) -> 4 cycles later out_valid=1, out_mant=0x8000_0000_0000_0000, out_exp=69, out_sub=0, out_zero=0.
2. Exponent limits shift: in_mant=0x00F0_0000_0000_0000, in_exp=5 (lz=8) -> sh=4, out_mant=0x0F00_0000_0000_0000, out_exp=0, out_sub=1.
3. Zero and boundary cases:
   - in_mant=0 (lz=64), in_exp=300 -> out_zero=1, out_mant=0, out_exp=0, out_sub=0.
   - in_mant=0x8000_0000_0000_0000, in_exp=1 -> unchanged, out_exp=1, out_sub=0.
4. Subnormal input: in_mant=0x0000_0000_0000_00FF, in_exp=0 -> out_mant unchanged, out_exp=0, out_sub=1. Also in_exp=1 with lz=63 -> sh=0, out_exp=0, out_sub=1.
5. Streaming: 200 random operands with random bubbles, including every sh value 0..63, checked against a behavioural model.
   - Every result arrives at exactly latency 4.
   - Outputs hold their values during bubbles.
   - The MSB invariant holds.
6. Reset mid-stream: assert rst_n=0 with 4 operands in flight -> out_valid and outputs drop to 0 asynchronously; after release with in_valid=0 for 10 cycles, out_valid stays 0.
